// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the cfg-write master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;

  localparam logic [1:0] SEL_PAYLOAD0 = 2'd0;
  localparam logic [1:0] SEL_PAYLOAD1 = 2'd1;
  localparam logic [1:0] SEL_SIZE     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte carried by a given write_select beat; size is zero-extended.
  function automatic logic [7:0] beat_byte(input logic [1:0] sel,
                                           input logic [7:0] p0,
                                           input logic [7:0] p1,
                                           input logic [4:0] size);
    case (sel)
      SEL_PAYLOAD0: return p0;
      SEL_PAYLOAD1: return p1;
      default:      return {3'b000, size};
    endcase
  endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Wait-state counter for an AHB data phase; flags the cycle whose increment
// would reach WAIT_TIMEOUT.
module ahb_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_timeout = i_inc && (r_count == LAST);

endmodule

// File: rtl/ahb_cfg_write_master.sv
// AHB-Lite initiator: writes payload0, payload1 and size as three pipelined
// NONSEQ byte beats, with error and wait-timeout abort.
module ahb_cfg_write_master
  import ahb_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_payload_0,
  input  logic [7:0] req_payload_1,
  input  logic [4:0] req_size,
  output logic       hsel_x,
  output logic       hwrite,
  output logic [1:0] htrans,
  output logic [2:0] hsize,
  output logic [1:0] write_select,
  output logic [7:0] hwdata,
  input  logic       hready,
  input  logic       hresp,
  output logic       done,
  output logic       done_err
);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_p0, r_p1;
  logic [4:0] r_size;
  logic       r_addr_valid, w_addr_valid_nxt;
  logic [1:0] r_addr_idx, w_addr_idx_nxt;
  logic       r_data_valid, w_data_valid_nxt;
  logic [1:0] r_data_idx, w_data_idx_nxt;
  logic       r_err, w_err_nxt;
  logic       w_latch;
  logic       w_wait_inc, w_wait_clr, w_timeout;

  assign w_wait_inc = (r_state == ST_BUSY) && r_data_valid && !hready;
  assign w_wait_clr = !w_wait_inc;

  ahb_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .i_clk    (hclk),
    .i_rst    (hreset),
    .i_inc    (w_wait_inc),
    .i_clr    (w_wait_clr),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_valid_nxt = r_addr_valid;
    w_addr_idx_nxt   = r_addr_idx;
    w_data_valid_nxt = r_data_valid;
    w_data_idx_nxt   = r_data_idx;
    w_err_nxt        = r_err;
    w_latch          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_latch          = 1'b1;
          w_state_nxt      = ST_BUSY;
          w_addr_valid_nxt = 1'b1;
          w_addr_idx_nxt   = SEL_PAYLOAD0;
          w_data_valid_nxt = 1'b0;
          w_err_nxt        = 1'b0;
        end
      end
      ST_BUSY: begin
        if (w_timeout) begin
          w_state_nxt      = ST_DONE;
          w_err_nxt        = 1'b1;
          w_addr_valid_nxt = 1'b0;
          w_data_valid_nxt = 1'b0;
        end else if (hready) begin
          if (r_data_valid && (r_err || hresp)) begin
            w_state_nxt      = ST_DONE;
            w_err_nxt        = 1'b1;
            w_addr_valid_nxt = 1'b0;
            w_data_valid_nxt = 1'b0;
          end else if (!r_addr_valid) begin
            w_state_nxt      = ST_DONE;
            w_data_valid_nxt = 1'b0;
          end else begin
            // Address phase k retires into data phase k; issue k+1 if any.
            w_data_valid_nxt = 1'b1;
            w_data_idx_nxt   = r_addr_idx;
            if (r_addr_idx == SEL_SIZE) begin
              w_addr_valid_nxt = 1'b0;
            end else begin
              w_addr_idx_nxt = r_addr_idx + 2'd1;
            end
          end
        end else if (r_data_valid && hresp) begin
          // First error cycle: drop the pending beat, finish on hready.
          w_err_nxt        = 1'b1;
          w_addr_valid_nxt = 1'b0;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_p0         <= '0;
      r_p1         <= '0;
      r_size       <= '0;
      r_addr_valid <= 1'b0;
      r_addr_idx   <= '0;
      r_data_valid <= 1'b0;
      r_data_idx   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_addr_valid <= w_addr_valid_nxt;
      r_addr_idx   <= w_addr_idx_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_data_idx   <= w_data_idx_nxt;
      r_err        <= w_err_nxt;
      if (w_latch) begin
        r_p0   <= req_payload_0;
        r_p1   <= req_payload_1;
        r_size <= req_size;
      end
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign hsel_x       = r_addr_valid || r_data_valid;
  assign hwrite       = r_addr_valid;
  assign htrans       = r_addr_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize        = HSIZE_BYTE;
  assign write_select = r_addr_valid ? r_addr_idx : SEL_PAYLOAD0;
  assign hwdata       = r_data_valid ? beat_byte(r_data_idx, r_p0, r_p1, r_size) : '0;
  assign done         = (r_state == ST_DONE);
  assign done_err     = (r_state == ST_DONE) && r_err;

endmodule

// File: tb/tb_ahb_cfg_write_master.sv
// Bench for ahb_cfg_write_master: reactive byte-slave model, latency and
// write-content expectations derived from the transaction-level rules.
module tb_ahb_cfg_write_master;

  localparam int TO = 4;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_payload_0;
  logic [7:0] req_payload_1;
  logic [4:0] req_size;
  logic       hsel_x;
  logic       hwrite;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [1:0] write_select;
  logic [7:0] hwdata;
  logic       hready;
  logic       hresp;
  logic       done;
  logic       done_err;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_cfg_write_master #(
    .WAIT_TIMEOUT(TO),
    .CNT_W       (5)
  ) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_payload_0(req_payload_0),
    .req_payload_1(req_payload_1),
    .req_size     (req_size),
    .hsel_x       (hsel_x),
    .hwrite       (hwrite),
    .htrans       (htrans),
    .hsize        (hsize),
    .write_select (write_select),
    .hwdata       (hwdata),
    .hready       (hready),
    .hresp        (hresp),
    .done         (done),
    .done_err     (done_err)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_hsel", hsel_x, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_hsize", hsize, 0);
    chk("rst_wsel", write_select, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
  endtask

  // One request; the slave side stalls/errs per the arguments
  // (pre = stall cycles during address phase 0, wK = stall cycles in data phase K).
  task automatic run_txn(input logic [7:0] p0, input logic [7:0] p1, input logic [4:0] sz,
                         input int pre, input int w0, input int w1, input int w2,
                         input int err_beat, input int to_beat);
    logic [7:0] eb [3];
    int         wl [3];
    bit         wr [3];
    logic [7:0] rv [3];
    int         abort_beat, exp_c, exp_addr, done_c, n_addr, dpi, left, est, pre_left, a_idx;
    bit         dpv, a_now, derr;
    logic [7:0] d_smp;
    eb[0] = p0; eb[1] = p1; eb[2] = {3'b000, sz};
    wl[0] = w0; wl[1] = w1; wl[2] = w2;
    if (to_beat >= 0) wl[to_beat] = 1000;
    abort_beat = (err_beat >= 0) ? err_beat : to_beat;
    exp_c    = 5 + pre + w0 + w1 + w2;
    exp_addr = 3;
    if (abort_beat >= 0) begin
      exp_c = 2 + pre + abort_beat + ((err_beat >= 0) ? 2 : TO);
      for (int j = 0; j < abort_beat; j++) exp_c += wl[j];
      exp_addr = abort_beat + 1;
    end
    for (int j = 0; j < 3; j++) begin wr[j] = 1'b0; rv[j] = '0; end
    done_c = -1; derr = 1'b0; n_addr = 0; dpv = 1'b0; dpi = 0; left = 0; est = 0;
    pre_left = pre;

    req_payload_0 = p0; req_payload_1 = p1; req_size = sz;
    req_valid = 1'b1; hready = 1'b1; hresp = 1'b0;
    tick();
    req_valid = 1'b0;
    req_payload_0 = 8'($urandom); req_payload_1 = 8'($urandom); req_size = 5'($urandom);

    for (int c = 1; c <= 60; c++) begin
      if (done === 1'b1) begin
        done_c = c;
        derr   = done_err;
        chk("done_hsel", hsel_x, 0);
        chk("done_htrans", htrans, 0);
        break;
      end
      chk("busy_req_ready", req_ready, 0);
      chk("busy_hsel", hsel_x, 1);
      if (htrans == 2'b10) begin
        chk("addr_order", write_select, n_addr);
        chk("addr_hwrite", hwrite, 1);
        chk("addr_hsize", hsize, 0);
      end
      if (dpv) chk("data_hwdata", hwdata, eb[dpi]);
      a_now = (htrans == 2'b10);
      a_idx = int'(write_select);
      d_smp = hwdata;
      if (dpv && dpi == err_beat) begin
        if (est == 0) begin
          hready = 1'b0; hresp = 1'b1; est = 1;
        end else begin
          chk("err_cancel_htrans", htrans, 0);
          hready = 1'b1; hresp = 1'b1;
        end
      end else if (dpv && left > 0) begin
        hready = 1'b0; hresp = 1'b0; left--;
      end else if (!dpv && pre_left > 0) begin
        hready = 1'b0; hresp = 1'b0; pre_left--;
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
      tick();
      if (hready) begin
        if (dpv && !hresp) begin wr[dpi] = 1'b1; rv[dpi] = d_smp; end
        if (a_now) n_addr++;
        dpv  = a_now;
        dpi  = a_idx;
        left = (a_idx < 3) ? wl[a_idx] : 0;
      end
    end

    chk("done_cycle", done_c, exp_c);
    chk("done_err", derr, abort_beat >= 0);
    chk("addr_count", n_addr, exp_addr);
    for (int j = 0; j < 3; j++) begin
      chk("beat_written", wr[j], (abort_beat < 0) || (j < abort_beat));
      if (wr[j]) chk("beat_data", rv[j], eb[j]);
    end
    hready = 1'b1; hresp = 1'b0;
    if (done_c >= 0) begin
      tick();
      chk("post_done", done, 0);
      chk("post_req_ready", req_ready, 1);
    end else begin
      hreset = 1'b1;
      tick();
      hreset = 1'b0;
      tick();
    end
  endtask

  initial begin
    int mode, beat, eb_, tb_;
    hreset = 1'b0; req_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
    req_payload_0 = '0; req_payload_1 = '0; req_size = '0;
    #1 hreset = 1'b1;
    #1 chk_reset_outputs();
    tick();
    hreset = 1'b0;
    tick();

    run_txn(8'hA5, 8'h3C, 5'd17, 0, 0, 0, 0, -1, -1);
    run_txn(8'hA5, 8'h3C, 5'd17, 0, 0, 3, 0, -1, -1);
    run_txn(8'hA5, 8'h3C, 5'd17, 0, 0, 0, 0, 0, -1);
    run_txn(8'hA5, 8'h3C, 5'd17, 0, 0, 0, 0, -1, 1);

    // Reset asserted in cycle 2 of a sequence.
    req_payload_0 = 8'h5A; req_payload_1 = 8'hC3; req_size = 5'd9;
    req_valid = 1'b1; hready = 1'b1; hresp = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("midrst_pre_htrans", htrans, 2'b10);
    hreset = 1'b1;
    #1 chk_reset_outputs();
    tick();
    hreset = 1'b0;
    tick();
    chk("midrst_no_resume_htrans", htrans, 0);
    chk("midrst_no_resume_ready", req_ready, 1);
    run_txn(8'h81, 8'h7E, 5'd31, 0, 0, 0, 0, -1, -1);

    // req_valid held high: DONE then IDLE between back-to-back sequences.
    req_payload_0 = 8'h11; req_payload_1 = 8'h22; req_size = 5'd3;
    req_valid = 1'b1; hready = 1'b1; hresp = 1'b0;
    tick();
    for (int c = 1; c <= 12; c++) begin
      chk("b2b_req_ready", req_ready, (c % 6) == 0);
      chk("b2b_done", done, (c % 6) == 5);
      chk("b2b_htrans", htrans, ((c % 6) >= 1 && (c % 6) <= 3) ? 2'b10 : 2'b00);
      if (c == 12) req_valid = 1'b0;
      tick();
    end

    for (int t = 0; t < 12; t++) begin
      mode = $urandom_range(0, 3);
      beat = $urandom_range(0, 2);
      eb_  = (mode == 2) ? beat : -1;
      tb_  = (mode == 3) ? beat : -1;
      run_txn(8'($urandom), 8'($urandom), 5'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), eb_, tb_);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
